// File: rtl/layer_slice_scheduler.sv
// rtl/layer_slice_scheduler.sv - layer-level (filter, slice) sequencer for the CNN slice controller
// Optional watchdog on the slice wait is enabled by defining SCHED_WATCHDOG_EN.
module layer_slice_scheduler #(
  parameter int CNT_WIDTH      = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  resetState,
  input  logic                  layerStart,
  input  logic                  layerConvPool,
  input  logic [CNT_WIDTH-1:0]  numFilters,
  input  logic [CNT_WIDTH-1:0]  numSlices,
  input  logic [ADDR_WIDTH-1:0] filterBase,
  input  logic [ADDR_WIDTH-1:0] inputBase,
  input  logic [ADDR_WIDTH-1:0] outputBase,
  input  logic [ADDR_WIDTH-1:0] filterWords,
  input  logic [ADDR_WIDTH-1:0] sliceWords,
  input  logic [ADDR_WIDTH-1:0] outWords,
  input  logic                  sliceFinish,
  output logic                  sliceStart,
  output logic                  convPoolSelect,
  output logic                  filterLastLayer,
  output logic [ADDR_WIDTH-1:0] filterAddr,
  output logic [ADDR_WIDTH-1:0] windowAddr,
  output logic [ADDR_WIDTH-1:0] outputAddr,
  output logic [CNT_WIDTH-1:0]  filterIdx,
  output logic [CNT_WIDTH-1:0]  sliceIdx,
  output logic                  busy,
  output logic                  layerDone,
  output logic                  timeoutErr
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_ISSUE, S_WAIT, S_RELEASE, S_ADVANCE, S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state_q;
  logic                  slice_start_q;
  logic                  layer_done_q;
  logic                  busy_q;
  logic                  mode_q;
  logic                  last_layer_q;
  logic [CNT_WIDTH-1:0]  nfilt_q;
  logic [CNT_WIDTH-1:0]  nslice_q;
  logic [CNT_WIDTH-1:0]  filter_idx_q;
  logic [CNT_WIDTH-1:0]  slice_idx_q;
  logic [ADDR_WIDTH-1:0] ibase_q;
  logic [ADDR_WIDTH-1:0] fwords_q;
  logic [ADDR_WIDTH-1:0] swords_q;
  logic [ADDR_WIDTH-1:0] owords_q;
  logic [ADDR_WIDTH-1:0] filter_addr_q;
  logic [ADDR_WIDTH-1:0] window_addr_q;
  logic [ADDR_WIDTH-1:0] output_addr_q;

  logic last_slice;
  logic last_filter;
  logic zero_count;
  logic next_is_last;

  // Compares run against latched counts, so a count of 2^CNT_WIDTH-1 never overflows idx.
  assign last_slice   = (slice_idx_q == nslice_q - CNT_ONE);
  assign last_filter  = mode_q | (filter_idx_q == nfilt_q - CNT_ONE);
  assign next_is_last = (slice_idx_q + CNT_ONE == nslice_q - CNT_ONE);
  assign zero_count   = (numSlices == '0) || (!layerConvPool && (numFilters == '0));

`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;
`endif

  always_ff @(posedge clk or posedge resetState) begin
    if (resetState) begin
      state_q       <= S_IDLE;
      slice_start_q <= 1'b0;
      layer_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      mode_q        <= 1'b0;
      last_layer_q  <= 1'b0;
      nfilt_q       <= '0;
      nslice_q      <= '0;
      filter_idx_q  <= '0;
      slice_idx_q   <= '0;
      ibase_q       <= '0;
      fwords_q      <= '0;
      swords_q      <= '0;
      owords_q      <= '0;
      filter_addr_q <= '0;
      window_addr_q <= '0;
      output_addr_q <= '0;
`ifdef SCHED_WATCHDOG_EN
      wd_q          <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      slice_start_q <= 1'b0;
      layer_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (layerStart) begin
            state_q <= S_LATCH;
            busy_q  <= 1'b1;
`ifdef SCHED_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        S_LATCH: begin
          mode_q        <= layerConvPool;
          nfilt_q       <= numFilters;
          nslice_q      <= numSlices;
          ibase_q       <= inputBase;
          fwords_q      <= filterWords;
          swords_q      <= sliceWords;
          owords_q      <= outWords;
          filter_idx_q  <= '0;
          slice_idx_q   <= '0;
          filter_addr_q <= filterBase;
          window_addr_q <= inputBase;
          output_addr_q <= outputBase;
          last_layer_q  <= layerConvPool | (numSlices == CNT_ONE);
          if (zero_count) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b1;
          end else begin
            state_q       <= S_ISSUE;
            slice_start_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
`ifdef SCHED_WATCHDOG_EN
          wd_q    <= '0;
`endif
        end
        S_WAIT: begin
          if (sliceFinish) begin
            state_q <= S_RELEASE;
`ifdef SCHED_WATCHDOG_EN
          end else if (wd_q == WD_LAST) begin
            timeout_q    <= 1'b1;
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b1;
          end else begin
            wd_q <= wd_q + WD_ONE;
`endif
          end
        end
        S_RELEASE: begin
          // Finish must drop before the next start, so one start matches one finish.
          if (!sliceFinish) state_q <= S_ADVANCE;
        end
        S_ADVANCE: begin
          if (last_slice && last_filter) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b1;
          end else begin
            state_q       <= S_ISSUE;
            slice_start_q <= 1'b1;
            if (mode_q) begin
              slice_idx_q   <= slice_idx_q + CNT_ONE;
              window_addr_q <= window_addr_q + swords_q;
              output_addr_q <= output_addr_q + owords_q;
            end else if (last_slice) begin
              // Filters are stored back to back, so filterAddr keeps accumulating.
              slice_idx_q   <= '0;
              filter_idx_q  <= filter_idx_q + CNT_ONE;
              filter_addr_q <= filter_addr_q + fwords_q;
              window_addr_q <= ibase_q;
              output_addr_q <= output_addr_q + owords_q;
              last_layer_q  <= (nslice_q == CNT_ONE);
            end else begin
              slice_idx_q   <= slice_idx_q + CNT_ONE;
              filter_addr_q <= filter_addr_q + fwords_q;
              window_addr_q <= window_addr_q + swords_q;
              last_layer_q  <= next_is_last;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sliceStart      = slice_start_q;
  assign convPoolSelect  = mode_q;
  assign filterLastLayer = last_layer_q;
  assign filterAddr      = filter_addr_q;
  assign windowAddr      = window_addr_q;
  assign outputAddr      = output_addr_q;
  assign filterIdx       = filter_idx_q;
  assign sliceIdx        = slice_idx_q;
  assign busy            = busy_q;
  assign layerDone       = layer_done_q;
`ifdef SCHED_WATCHDOG_EN
  assign timeoutErr      = timeout_q;
`else
  assign timeoutErr      = 1'b0;
`endif

endmodule

// File: tb/tb_layer_slice_scheduler.sv
// tb/tb_layer_slice_scheduler.sv - directed self-checking bench for layer_slice_scheduler
module tb_layer_slice_scheduler;

  logic        clk = 1'b0;
  logic        resetState = 1'b1;
  logic        layerStart = 1'b0;
  logic        layerConvPool = 1'b0;
  logic [7:0]  numFilters = '0;
  logic [7:0]  numSlices = '0;
  logic [15:0] filterBase = '0, inputBase = '0, outputBase = '0;
  logic [15:0] filterWords = '0, sliceWords = '0, outWords = '0;
  logic        sliceFinish = 1'b0;
  logic        sliceStart, convPoolSelect, filterLastLayer, busy, layerDone, timeoutErr;
  logic [15:0] filterAddr, windowAddr, outputAddr;
  logic [7:0]  filterIdx, sliceIdx;

  always #5 clk = ~clk;

  layer_slice_scheduler #(.CNT_WIDTH(8), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetState(resetState), .layerStart(layerStart), .layerConvPool(layerConvPool),
    .numFilters(numFilters), .numSlices(numSlices), .filterBase(filterBase), .inputBase(inputBase),
    .outputBase(outputBase), .filterWords(filterWords), .sliceWords(sliceWords), .outWords(outWords),
    .sliceFinish(sliceFinish), .sliceStart(sliceStart), .convPoolSelect(convPoolSelect),
    .filterLastLayer(filterLastLayer), .filterAddr(filterAddr), .windowAddr(windowAddr),
    .outputAddr(outputAddr), .filterIdx(filterIdx), .sliceIdx(sliceIdx), .busy(busy),
    .layerDone(layerDone), .timeoutErr(timeoutErr)
  );

  typedef struct {
    int          f;
    int          s;
    logic [15:0] fa;
    logic [15:0] wa;
    logic [15:0] oa;
    logic        fll;
    int          cyc;
  } rec_t;

  rec_t rec_q[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic done_busy = 1'b0;
  logic done_to = 1'b0;
  int   vec = 0;
  int   miss = 0;
  int   resp_en = 0;
  int   resp_delay = 5;
  int   resp_hold = 1;

  // Monitor: samples 1ns after each rising edge; cyc counts rising edges.
  initial begin
    rec_t r;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sliceStart === 1'b1) begin
        r.f = int'(filterIdx); r.s = int'(sliceIdx);
        r.fa = filterAddr; r.wa = windowAddr; r.oa = outputAddr;
        r.fll = filterLastLayer; r.cyc = cyc;
        rec_q.push_back(r);
      end
      if (layerDone === 1'b1) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
        done_to   = timeoutErr;
      end
    end
  end

  // Slice controller model: finish rises resp_delay cycles after a start, held resp_hold cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (sliceStart === 1'b1 && resp_en != 0) begin
        repeat (resp_delay) @(negedge clk);
        sliceFinish = 1'b1;
        repeat (resp_hold) @(negedge clk);
        sliceFinish = 1'b0;
      end
    end
  end

  task automatic start_layer(input logic conv_pool, input int nf, input int ns,
                             input logic [15:0] fw, input logic [15:0] sw, input logic [15:0] ow,
                             output int sc);
    @(negedge clk);
    layerConvPool = conv_pool;
    numFilters = 8'(nf); numSlices = 8'(ns);
    filterWords = fw; sliceWords = sw; outWords = ow;
    rec_q.delete();
    done_cnt = 0;
    layerStart = 1'b1;
    sc = cyc;
    @(negedge clk);
    layerStart = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetState = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if ({sliceStart, convPoolSelect, filterLastLayer, busy, layerDone, timeoutErr} !== 6'b0) begin
      miss++; $display("FAIL reset_flags got %b want 000000",
        {sliceStart, convPoolSelect, filterLastLayer, busy, layerDone, timeoutErr});
    end
    vec++;
    if ({filterAddr, windowAddr, outputAddr, filterIdx, sliceIdx} !== 64'h0) begin
      miss++; $display("FAIL reset_regs got %h want 0", {filterAddr, windowAddr, outputAddr, filterIdx, sliceIdx});
    end
    resetState = 1'b0;
  endtask

  task automatic test_conv();
    int sc; bit ok;
    filterBase = 16'h100; inputBase = 16'h400; outputBase = 16'h800;
    resp_en = 1; resp_delay = 5; resp_hold = 1;
    start_layer(1'b0, 2, 3, 16'd9, 16'd25, 16'd9, sc);
    vec++;
    if (busy !== 1'b1) begin miss++; $display("FAIL conv_busy_latch got %b want 1", busy); end
    wait_done(400, ok);
    vec++;
    if (!ok) begin miss++; $display("FAIL conv_done_timeout got 0 want 1"); end
    vec++;
    if (rec_q.size() != 6) begin miss++; $display("FAIL conv_start_count got %0d want 6", rec_q.size()); end
    if (rec_q.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        vec++;
        if (rec_q[k].f != k / 3 || rec_q[k].s != k % 3) begin
          miss++; $display("FAIL conv_idx[%0d] got (%0d,%0d) want (%0d,%0d)", k, rec_q[k].f, rec_q[k].s, k / 3, k % 3);
        end
        vec++;
        if (rec_q[k].fa !== 16'(16'h100 + 9 * k)) begin
          miss++; $display("FAIL conv_faddr[%0d] got %h want %h", k, rec_q[k].fa, 16'(16'h100 + 9 * k));
        end
        vec++;
        if (rec_q[k].wa !== 16'(16'h400 + 25 * (k % 3))) begin
          miss++; $display("FAIL conv_waddr[%0d] got %h want %h", k, rec_q[k].wa, 16'(16'h400 + 25 * (k % 3)));
        end
        vec++;
        if (rec_q[k].oa !== 16'(16'h800 + 9 * (k / 3))) begin
          miss++; $display("FAIL conv_oaddr[%0d] got %h want %h", k, rec_q[k].oa, 16'(16'h800 + 9 * (k / 3)));
        end
        vec++;
        if (rec_q[k].fll !== (k % 3 == 2)) begin
          miss++; $display("FAIL conv_fll[%0d] got %b want %b", k, rec_q[k].fll, (k % 3 == 2));
        end
      end
      vec++;
      if (rec_q[0].cyc - sc != 2) begin miss++; $display("FAIL conv_first_latency got %0d want 2", rec_q[0].cyc - sc); end
      vec++;
      if (rec_q[1].cyc - rec_q[0].cyc != 8) begin miss++; $display("FAIL conv_slice_gap got %0d want 8", rec_q[1].cyc - rec_q[0].cyc); end
      vec++;
      if (done_cyc - rec_q[5].cyc != 8) begin miss++; $display("FAIL conv_done_latency got %0d want 8", done_cyc - rec_q[5].cyc); end
    end
    vec++;
    if (done_busy !== 1'b0 || done_to !== 1'b0) begin
      miss++; $display("FAIL conv_done_flags got busy=%b to=%b want busy=0 to=0", done_busy, done_to);
    end
    repeat (4) @(negedge clk);
    vec++;
    if (done_cnt != 1) begin miss++; $display("FAIL conv_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_pool();
    int sc; bit ok;
    filterBase = 16'h100; inputBase = 16'h400; outputBase = 16'h800;
    resp_en = 1; resp_delay = 5; resp_hold = 1;
    start_layer(1'b1, 7, 4, 16'd9, 16'd25, 16'd4, sc);
    wait_done(300, ok);
    vec++;
    if (!ok) begin miss++; $display("FAIL pool_done_timeout got 0 want 1"); end
    vec++;
    if (rec_q.size() != 4) begin miss++; $display("FAIL pool_start_count got %0d want 4", rec_q.size()); end
    if (rec_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        vec++;
        if (rec_q[k].f != 0 || rec_q[k].s != k || rec_q[k].fll !== 1'b1) begin
          miss++; $display("FAIL pool_idx[%0d] got (%0d,%0d,fll=%b) want (0,%0d,fll=1)", k, rec_q[k].f, rec_q[k].s, rec_q[k].fll, k);
        end
        vec++;
        if (rec_q[k].oa !== 16'(16'h800 + 4 * k) || rec_q[k].wa !== 16'(16'h400 + 25 * k)) begin
          miss++; $display("FAIL pool_addr[%0d] got o=%h w=%h want o=%h w=%h", k, rec_q[k].oa, rec_q[k].wa,
                           16'(16'h800 + 4 * k), 16'(16'h400 + 25 * k));
        end
      end
    end
    vec++;
    if (convPoolSelect !== 1'b1) begin miss++; $display("FAIL pool_select got %b want 1", convPoolSelect); end
  endtask

  task automatic test_zero_count();
    int sc; bit ok;
    resp_en = 1;
    start_layer(1'b0, 2, 0, 16'd9, 16'd25, 16'd9, sc);
    wait_done(20, ok);
    vec++;
    if (!ok || rec_q.size() != 0 || done_cyc - sc != 2) begin
      miss++; $display("FAIL zero_slices got ok=%0d starts=%0d lat=%0d want ok=1 starts=0 lat=2", ok, rec_q.size(), done_cyc - sc);
    end
    start_layer(1'b0, 0, 3, 16'd9, 16'd25, 16'd9, sc);
    wait_done(20, ok);
    vec++;
    if (!ok || rec_q.size() != 0 || done_cyc - sc != 2) begin
      miss++; $display("FAIL zero_filters got ok=%0d starts=%0d lat=%0d want ok=1 starts=0 lat=2", ok, rec_q.size(), done_cyc - sc);
    end
  endtask

  task automatic test_back_to_back();
    int sc; bit ok;
    filterBase = 16'h100; inputBase = 16'h400; outputBase = 16'h800;
    resp_en = 1; resp_delay = 5; resp_hold = 10;
    start_layer(1'b0, 1, 2, 16'd9, 16'd25, 16'd9, sc);
    repeat (3) @(negedge clk);
    numSlices = 8'd5;
    layerStart = 1'b1;
    @(negedge clk);
    layerStart = 1'b0;
    wait_done(300, ok);
    repeat (6) @(negedge clk);
    vec++;
    if (!ok || rec_q.size() != 2) begin miss++; $display("FAIL hold_start_count got %0d want 2", rec_q.size()); end
    if (rec_q.size() == 2) begin
      vec++;
      if (rec_q[1].cyc - rec_q[0].cyc != 17) begin
        miss++; $display("FAIL hold_slice_gap got %0d want 17", rec_q[1].cyc - rec_q[0].cyc);
      end
    end
    vec++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      miss++; $display("FAIL hold_ignored_start got done=%0d busy=%b want done=1 busy=0", done_cnt, busy);
    end
    resp_hold = 1;
  endtask

  task automatic test_reset_in_wait();
    int sc; bit ok;
    filterBase = 16'h100; inputBase = 16'h400; outputBase = 16'h800;
    resp_en = 0;
    start_layer(1'b1, 0, 3, 16'd9, 16'd25, 16'd4, sc);
    repeat (3) @(negedge clk);
    vec++;
    if (busy !== 1'b1 || filterLastLayer !== 1'b1) begin
      miss++; $display("FAIL rst_pre_state got busy=%b fll=%b want 1 1", busy, filterLastLayer);
    end
    #2 resetState = 1'b1;
    #1;
    vec++;
    if ({sliceStart, convPoolSelect, filterLastLayer, busy, layerDone, timeoutErr} !== 6'b0) begin
      miss++; $display("FAIL rst_async_flags got %b want 000000",
        {sliceStart, convPoolSelect, filterLastLayer, busy, layerDone, timeoutErr});
    end
    vec++;
    if ({filterAddr, windowAddr, outputAddr} !== 48'h0) begin
      miss++; $display("FAIL rst_async_addr got %h %h %h want 0", filterAddr, windowAddr, outputAddr);
    end
    @(negedge clk);
    resetState = 1'b0;
    resp_en = 1; resp_delay = 5; resp_hold = 1;
    start_layer(1'b1, 0, 2, 16'd9, 16'd25, 16'd4, sc);
    wait_done(200, ok);
    vec++;
    if (!ok || rec_q.size() != 2) begin miss++; $display("FAIL rst_rerun_count got %0d want 2", rec_q.size()); end
    if (rec_q.size() == 2) begin
      vec++;
      if (rec_q[0].cyc - sc != 2 || rec_q[1].oa !== 16'h804) begin
        miss++; $display("FAIL rst_rerun got lat=%0d oa=%h want lat=2 oa=0804", rec_q[0].cyc - sc, rec_q[1].oa);
      end
    end
  endtask

  task automatic test_max_count();
    int sc; bit ok; int n;
    inputBase = 16'h400; outputBase = 16'hFF00;
    resp_en = 1; resp_delay = 1; resp_hold = 1;
    start_layer(1'b1, 0, 255, 16'd9, 16'd25, 16'd2, sc);
    wait_done(3000, ok);
    n = rec_q.size();
    vec++;
    if (!ok || n != 255) begin miss++; $display("FAIL max_start_count got %0d want 255", n); end
    if (n == 255) begin
      vec++;
      if (rec_q[254].s != 254 || rec_q[254].oa !== 16'h00FC || rec_q[254].wa !== 16'h1CCE) begin
        miss++; $display("FAIL max_last got s=%0d oa=%h wa=%h want s=254 oa=00fc wa=1cce",
                         rec_q[254].s, rec_q[254].oa, rec_q[254].wa);
      end
    end
    resp_delay = 5;
  endtask

`ifdef SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    int sc; bit ok;
    resp_en = 0;
    start_layer(1'b0, 1, 1, 16'd9, 16'd25, 16'd9, sc);
    wait_done(100, ok);
    vec++;
    if (!ok || done_cyc - sc != 19 || done_to !== 1'b1) begin
      miss++; $display("FAIL wd_timeout got ok=%0d lat=%0d err=%b want ok=1 lat=19 err=1", ok, done_cyc - sc, done_to);
    end
    resp_en = 1;
    start_layer(1'b1, 0, 1, 16'd9, 16'd25, 16'd4, sc);
    vec++;
    if (timeoutErr !== 1'b0) begin miss++; $display("FAIL wd_clear got %b want 0", timeoutErr); end
    wait_done(100, ok);
  endtask
`endif

  initial begin
    test_reset();
    test_conv();
    test_pool();
    test_zero_count();
    test_back_to_back();
    test_reset_in_wait();
    test_max_count();
`ifdef SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
